// File: rtl/msu_pkg.sv
// Shared constants, word-offset map and FSM state type for the MSU host adapter.
// The word offsets below assume T_LEN == 2*AXI_LEN, which is the shipped configuration.
package msu_pkg;

  // Word offsets inside the tx (job) and rx (result) streams.
  localparam int T_START   = 0;
  localparam int T_FINAL   = 2;
  localparam int SQ_IN     = 4;
  localparam int T_CURRENT = 0;
  localparam int SQ_OUT    = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RECV = 2'd2,
    DONE = 2'd3
  } state_t;

  // Job words: two iteration counters followed by reduced limbs packed two per word.
  function automatic int axi_in_count(input int t_len, input int axi_len, input int nonred);
    return 2 * t_len / axi_len + (nonred + 1) / 2;
  endfunction

  // Result words: one iteration counter followed by one redundant limb per word.
  function automatic int axi_out_count(input int t_len, input int axi_len, input int num_el);
    return t_len / axi_len + num_el;
  endfunction

endpackage

// File: rtl/msu_host_xfer_if.sv
// AXI-stream style word channel between the host adapter and the MSU.
// The master side drives data/valid, the slave side drives ready.
interface msu_host_xfer_if #(
  parameter int AXI_LEN = 32
);
  logic                   tvalid;
  logic                   tready;
  logic [AXI_LEN-1:0]     tdata;
  logic [AXI_LEN/8-1:0]   tkeep;
  logic                   tlast;

  modport master (output tvalid, tdata, tkeep, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/msu_rx_unpack.sv
// Result word store: unpacks t_current and redundant limbs, flags nonzero pad bits.
// Latency: a word written on one edge is visible on the outputs after that edge.
// Backpressure: none; every wr_en word is stored (caller owns the handshake).
module msu_rx_unpack
  import msu_pkg::*;
#(
  parameter int AXI_LEN      = 32,
  parameter int T_LEN        = 64,
  parameter int BIT_LEN      = 17,
  parameter int NUM_ELEMENTS = 10,
  parameter int CNT_W        = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            wr_en,
  input  logic [CNT_W-1:0]                wr_idx,
  input  logic [AXI_LEN-1:0]              wr_dat,
  output logic [T_LEN-1:0]                t_current,
  output logic [NUM_ELEMENTS*BIT_LEN-1:0] sq_out,
  output logic                            err_fmt
);

  localparam int T_WORDS = T_LEN / AXI_LEN;

  // Steer each accepted word into its slot; pad bits above a limb are an error but the limb is kept.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      t_current <= '0;
      sq_out    <= '0;
      err_fmt   <= 1'b0;
    end else if (wr_en) begin
      for (int w = 0; w < T_WORDS; w++) begin
        if (wr_idx == CNT_W'(T_CURRENT + w)) t_current[w*AXI_LEN +: AXI_LEN] <= wr_dat;
      end
      for (int i = 0; i < NUM_ELEMENTS; i++) begin
        if (wr_idx == CNT_W'(SQ_OUT + i)) sq_out[i*BIT_LEN +: BIT_LEN] <= wr_dat[BIT_LEN-1:0];
      end
      if ((wr_idx >= CNT_W'(SQ_OUT)) && (|wr_dat[AXI_LEN-1:BIT_LEN])) err_fmt <= 1'b1;
    end
  end

endmodule

// File: rtl/msu_host_xfer.sv
// Host-side MSU driver: serialises one squaring job, then collects and unpacks the result.
// Latency: job accept -> first tx beat 1 cycle; last rx beat -> result_valid 1 cycle.
// Backpressure: tx word held while m_axis.tready low; result held until result_ready.
module msu_host_xfer
  import msu_pkg::*;
#(
  parameter int AXI_LEN               = 32,
  parameter int C_XFER_SIZE_WIDTH     = 32,
  parameter int REDUNDANT_ELEMENTS    = 2,
  parameter int NONREDUNDANT_ELEMENTS = 8,
  parameter int NUM_ELEMENTS          = NONREDUNDANT_ELEMENTS + REDUNDANT_ELEMENTS,
  parameter int BIT_LEN               = 17,
  parameter int WORD_LEN              = 16,
  parameter int T_LEN                 = 64
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  logic                                    job_valid,
  output logic                                    job_ready,
  input  logic [T_LEN-1:0]                        job_t_start,
  input  logic [T_LEN-1:0]                        job_t_final,
  input  logic [NONREDUNDANT_ELEMENTS*WORD_LEN-1:0] job_sq_in,
  msu_host_xfer_if.master                         m_axis,
  msu_host_xfer_if.slave                          s_axis,
  input  logic [C_XFER_SIZE_WIDTH-1:0]            msu_in_xfer_size,
  input  logic [C_XFER_SIZE_WIDTH-1:0]            msu_out_xfer_size,
  output logic                                    result_valid,
  input  logic                                    result_ready,
  output logic [T_LEN-1:0]                        result_t_current,
  output logic [NUM_ELEMENTS*BIT_LEN-1:0]         result_sq_out,
  output logic                                    busy,
  output logic                                    err_size,
  output logic                                    err_fmt
);

  localparam int IN_CNT  = axi_in_count(T_LEN, AXI_LEN, NONREDUNDANT_ELEMENTS);
  localparam int OUT_CNT = axi_out_count(T_LEN, AXI_LEN, NUM_ELEMENTS);
  localparam int CNT_W   = $clog2((IN_CNT > OUT_CNT) ? IN_CNT : OUT_CNT);
  localparam int T_WORDS = T_LEN / AXI_LEN;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [AXI_LEN-1:0] tx_sr   [IN_CNT];
  logic [AXI_LEN-1:0] tx_load [IN_CNT];
  logic               rx_wr_en;
  logic               unused_ok;

  // Build the job word image: counters LS word first, then reduced limbs two per word.
  always_comb begin
    for (int w = 0; w < IN_CNT; w++) tx_load[w] = '0;
    for (int w = 0; w < T_WORDS; w++) begin
      tx_load[T_START + w] = job_t_start[w*AXI_LEN +: AXI_LEN];
      tx_load[T_FINAL + w] = job_t_final[w*AXI_LEN +: AXI_LEN];
    end
    for (int l = 0; l < NONREDUNDANT_ELEMENTS; l++) begin
      if (l % 2 == 0) tx_load[SQ_IN + l/2][WORD_LEN-1:0]          = job_sq_in[l*WORD_LEN +: WORD_LEN];
      else            tx_load[SQ_IN + l/2][AXI_LEN/2 +: WORD_LEN] = job_sq_in[l*WORD_LEN +: WORD_LEN];
    end
  end

  // State and beat counter register; reset aborts any transfer in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and handshake decode; every valid/ready output comes from registered state only.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    job_ready     = 1'b0;
    m_axis.tvalid = 1'b0;
    m_axis.tlast  = 1'b0;
    s_axis.tready = 1'b0;
    result_valid  = 1'b0;
    unique case (state_q)
      IDLE: begin
        job_ready = 1'b1;
        if (job_valid) begin
          state_d = SEND;
          cnt_d   = '0;
        end
      end
      SEND: begin
        m_axis.tvalid = 1'b1;
        m_axis.tlast  = (cnt_q == CNT_W'(IN_CNT - 1));
        if (m_axis.tready) begin
          if (m_axis.tlast) begin
            state_d = RECV;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RECV: begin
        s_axis.tready = 1'b1;
        if (s_axis.tvalid) begin
          if (cnt_q == CNT_W'(OUT_CNT - 1)) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        result_valid = 1'b1;
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Tx shift register loads on accept and advances only on a taken beat; size check is sticky.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int w = 0; w < IN_CNT; w++) tx_sr[w] <= '0;
      err_size <= 1'b0;
    end else if (state_q == IDLE && job_valid) begin
      tx_sr <= tx_load;
      if ((msu_in_xfer_size  != C_XFER_SIZE_WIDTH'(IN_CNT  * AXI_LEN / 8)) ||
          (msu_out_xfer_size != C_XFER_SIZE_WIDTH'(OUT_CNT * AXI_LEN / 8)))
        err_size <= 1'b1;
    end else if (state_q == SEND && m_axis.tready) begin
      for (int w = 0; w < IN_CNT - 1; w++) tx_sr[w] <= tx_sr[w+1];
      tx_sr[IN_CNT-1] <= '0;
    end
  end

  assign m_axis.tdata = tx_sr[0];
  assign m_axis.tkeep = '1;
  assign busy         = (state_q != IDLE);
  assign rx_wr_en     = (state_q == RECV) && s_axis.tvalid;
  assign unused_ok    = ^{s_axis.tkeep, s_axis.tlast};

  msu_rx_unpack #(
    .AXI_LEN      (AXI_LEN),
    .T_LEN        (T_LEN),
    .BIT_LEN      (BIT_LEN),
    .NUM_ELEMENTS (NUM_ELEMENTS),
    .CNT_W        (CNT_W)
  ) u_rx_unpack (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (rx_wr_en),
    .wr_idx    (cnt_q),
    .wr_dat    (s_axis.tdata),
    .t_current (result_t_current),
    .sq_out    (result_sq_out),
    .err_fmt   (err_fmt)
  );

endmodule
